// File: rtl/reduce_tree_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reduce_pkg
// Description : Shared mode encodings and bit-combine helpers for the
//               pipelined reduction tree.
// Revision    : 1.0 - initial release
// ============================================================================
package reduce_pkg;

    typedef logic [1:0] red_mode_t;

    localparam red_mode_t RED_OR   = 2'b00;
    localparam red_mode_t RED_AND  = 2'b01;
    localparam red_mode_t RED_XOR  = 2'b10;
    localparam red_mode_t RED_NAND = 2'b11;

    // Neutral padding bit: never changes the reduction result.
    function automatic logic red_identity(input red_mode_t mode);
        return (mode == RED_AND) || (mode == RED_NAND);
    endfunction

    // NAND combines as AND; inversion happens once at the tree output.
    function automatic logic red_combine(input red_mode_t mode, input logic a, input logic b);
        case (mode)
            RED_OR:  return a | b;
            RED_XOR: return a ^ b;
            default: return a & b;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_tree_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : reduce_tree_pipe_if
// Description : Valid/ready input and output channels of the reduction tree.
// Revision    : 1.0 - initial release
// ============================================================================
interface reduce_tree_pipe_if
    import reduce_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    red_mode_t        in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_data;
    red_mode_t        out_mode;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface
`default_nettype wire

// File: rtl/reduce_tree_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : reduce_stage
// Description : One tree level: pairwise combine IN_W -> IN_W/2 bits with a
//               bubble-collapsing register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_valid,
    input  wire logic [IN_W-1:0]   i_data,
    input  wire red_mode_t         i_mode,
    input  wire logic              i_next_load,
    output logic                   o_load,
    output logic                   o_valid,
    output logic [IN_W/2-1:0]      o_data,
    output red_mode_t              o_mode
);
    localparam int OUT_W = IN_W / 2;

    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    red_mode_t        r_mode;
    logic [OUT_W-1:0] w_comb;

    always_comb begin
        w_comb = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_comb[i] = red_combine(i_mode, i_data[2*i], i_data[2*i+1]);
        end
    end

    assign o_load = ~r_valid | i_next_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_mode  <= RED_OR;
        end else if (o_load) begin
            r_valid <= i_valid;
            // Payload is only captured for real words so bubbles leave it quiet.
            if (i_valid) begin
                r_data <= w_comb;
                r_mode <= i_mode;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_mode  = r_mode;
endmodule
`default_nettype wire

// File: rtl/reduce_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : reduce_tree_pipe
// Description : Pipelined N-way OR/AND/XOR/NAND bit reduction, one register
//               level per tree level, full valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    reduce_tree_pipe_if.slave  bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int PAD_W  = 1 << LEVELS;
    localparam int LAST   = LEVELS - 1;

    logic [PAD_W-1:0] w_pad;

    generate
        if (PAD_W > WIDTH) begin : g_pad
            logic w_id;
            assign w_id  = red_identity(bus.in_mode);
            assign w_pad = {{(PAD_W-WIDTH){w_id}}, bus.in_data};
        end else begin : g_nopad
            assign w_pad = bus.in_data;
        end
    endgenerate

    generate
        for (genvar k = 0; k < LEVELS; k++) begin : g_stage
            localparam int IN_W  = PAD_W >> k;
            localparam int OUT_W = IN_W / 2;

            logic [IN_W-1:0]  w_in_data;
            logic             w_in_valid;
            red_mode_t        w_in_mode;
            logic             w_next_load;
            logic             w_load;
            logic             w_valid;
            logic [OUT_W-1:0] w_data;
            red_mode_t        w_mode;

            if (k == 0) begin : g_head
                assign w_in_data  = w_pad;
                assign w_in_valid = bus.in_valid;
                assign w_in_mode  = bus.in_mode;
            end else begin : g_body
                assign w_in_data  = g_stage[k-1].w_data;
                assign w_in_valid = g_stage[k-1].w_valid;
                assign w_in_mode  = g_stage[k-1].w_mode;
            end

            if (k == LEVELS - 1) begin : g_tail
                assign w_next_load = bus.out_ready;
            end else begin : g_link
                assign w_next_load = g_stage[k+1].w_load;
            end

            reduce_stage #(
                .IN_W (IN_W)
            ) u_stage (
                .clk         (clk),
                .reset       (reset),
                .i_valid     (w_in_valid),
                .i_data      (w_in_data),
                .i_mode      (w_in_mode),
                .i_next_load (w_next_load),
                .o_load      (w_load),
                .o_valid     (w_valid),
                .o_data      (w_data),
                .o_mode      (w_mode)
            );
        end
    endgenerate

    // Ready chains back from out_ready through the stage valids; reset masks it.
    assign bus.in_ready  = g_stage[0].w_load & ~reset;
    assign bus.out_valid = g_stage[LAST].w_valid;
    assign bus.out_mode  = g_stage[LAST].w_mode;
    assign bus.out_data  = (g_stage[LAST].w_mode == RED_NAND) ? ~g_stage[LAST].w_data[0]
                                                              :  g_stage[LAST].w_data[0];
endmodule
`default_nettype wire
